// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package riscv_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned WDOG_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    F_NONE         = 2'd0,
    F_ILLEGAL      = 2'd1,
    F_IMEM_TIMEOUT = 2'd2,
    F_DMEM_TIMEOUT = 2'd3
  } fault_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    case (op)
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive wait cycles of a memory phase; expired flags the last allowed cycle.
module ack_watchdog
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + WDOG_W'(1);
    end
  end

  // cnt holds cycles already spent, so the current cycle is number cnt+1
  assign expired = enable && (cnt == WDOG_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with run/step control,
// memory-ack watchdog and retired-instruction counter.
module multicycle_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [6:0]       opcode,
  input  logic             reg_write_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [2:0]       state_o,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  seq_state_t       state, state_next;
  fault_t           fault_q, fault_next;
  logic             step_q, step_rise;
  logic             store_q;
  logic             wd_clear, wd_enable, wd_expired;
  logic [CNT_W-1:0] retired_q;

  assign step_rise = step & ~step_q;
  assign wd_enable = (state == S_FETCH) || (state == S_MEM);
  assign wd_clear  = (state_next != state);

  ack_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and trap cause; an ack on the watchdog's last cycle still wins
  always_comb begin
    state_next = state;
    fault_next = fault_q;
    case (state)
      S_IDLE:   if (run || step_rise) state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_next = S_DECODE;
        end else if (wd_expired) begin
          state_next = S_TRAP;
          fault_next = F_IMEM_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!is_rv32i_opcode(opcode)) begin
          state_next = S_TRAP;
          fault_next = F_ILLEGAL;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC:   state_next = (mem_read_i || mem_write_i) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_next = S_WB;
        end else if (wd_expired) begin
          state_next = S_TRAP;
          fault_next = F_DMEM_TIMEOUT;
        end
      end
      S_WB:     state_next = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
  end

  // Strobe decode; ir_we and rf_we also look at same-cycle inputs
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    trap     = 1'b0;
    case (state)
      S_IDLE:  halted = 1'b1;
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = store_q;
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = reg_write_i & ~mem_write_i;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  // Step edge detector, store flag captured in EXEC, fault and retire count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q    <= 1'b0;
      store_q   <= 1'b0;
      fault_q   <= F_NONE;
      retired_q <= '0;
    end else begin
      step_q  <= step;
      fault_q <= fault_next;
      if (state == S_EXEC) store_q <= mem_write_i;
      if (state == S_WB) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state_o = state;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32I core. It steps the existing datapath through FETCH, DECODE, EXEC, MEM and WB phases instead of completing each instruction in one cycle. It sits between the decoding control unit and the state elements (PC, instruction register, register file, data memory), and qualifies their write and request strobes per phase. It also adds run/single-step control, a memory-ack watchdog and a retired-instruction counter.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles a memory request may wait for ack before trapping; legal range 1..65535.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  free-run enable, level-sensitive.
- `step`  in  1  single-step request; its rising edge is used.
- `opcode`  in  7  `Inst[6:0]` from the instruction register.
- `reg_write_i`, `mem_read_i`, `mem_write_i`  in  1 each  decoded control from the control unit.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch data valid.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  store qualifier.
- `dmem_ack`  in  1  data access complete.
- `ir_we`  out  1  instruction-register load.
- `pc_we`  out  1  PC update.
- `rf_we`  out  1  register-file write.
- `state_o`  out  3  current state encoding.
- `halted`  out  1  high in IDLE.
- `trap`  out  1  high in TRAP.
- `fault`  out  2  trap cause: 0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **IDLE**
  - `halted`=1.
  - Goes to FETCH if `run`=1 or a `step` rising edge is seen.
  - `step` is edge-detected through one register, so a held-high `step` yields exactly one instruction.
- **FETCH**
  - `imem_req`=1 until `imem_ack`.
  - On ack: `ir_we`=1 in that same cycle, then go to DECODE.
- **DECODE** (one cycle)
  - If `opcode` is not in the RV32I set (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111), go to TRAP with `fault`=1.
  - Otherwise go to EXEC.
- **EXEC** (one cycle)
  - Go to MEM if `mem_read_i` or `mem_write_i` is set.
  - Otherwise go to WB.
- **MEM**
  - `dmem_req`=1 and `dmem_we`=`mem_write_i`, held until `dmem_ack`, then go to WB.
- **WB** (one cycle)
  - `pc_we`=1.
  - `rf_we`=`reg_write_i` & ~`mem_write_i`.
  - `retired` increments.
  - Next state is FETCH if `run`=1, otherwise IDLE.
- **TRAP**
  - All strobes 0, `trap`=1, `fault` held.
  - Exited only by reset.
- **Watchdog**
  - Counts consecutive cycles in FETCH without ack, or in MEM without ack.
  - Cleared on state entry.
  - When the count reaches `TIMEOUT_CYCLES`, go to TRAP with `fault`=2 (FETCH) or 3 (MEM).
  - An ack arriving in the same cycle as the limit wins: normal transition.
- **Run/step changes**
  - `run` deasserting mid-instruction: the instruction completes and the sequencer parks in IDLE after WB.
  - `step` edges outside IDLE are ignored and not queued.
- `retired` wraps modulo 2^CNT_W.

## Timing
- **Reset values:** state IDLE; `halted`=1; all other outputs 0; `retired`=0; `fault`=0.
- **Reset mid-operation:** outstanding requests drop asynchronously. No strobe may glitch high during reset.
- **Output timing:**
  - `imem_req`, `dmem_req`, `dmem_we`, `pc_we`, `halted`, `trap` are Moore outputs of the registered state.
  - `ir_we` and `rf_we` combine the registered state with same-cycle inputs.
- **Acks:** an ack in the first request cycle is legal and completes that phase.
- **Latency from FETCH entry, zero-wait memory:**
  - ALU, branch and jump instructions: 4 cycles.
  - Loads and stores: 5 cycles.
  - Each memory wait cycle adds 1.
- **Throughput with `run`=1:** FETCH is entered the cycle after WB, with no idle bubble.
- **Single step:** from a `step` rising edge in IDLE, FETCH is entered 1 cycle later (edge-detect register).

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum `seq_state_t`;
  - RV32I opcode constants;
  - the fault enum `fault_t`.
- Sub-module `ack_watchdog`:
  - loadable up-counter with `clear`, `enable` and `expired` outputs;
  - parameterised by `TIMEOUT_CYCLES`;
  - instantiated once and shared by FETCH and MEM.

## Test plan
- **Free-run ADD:** `run`=1 with immediate acks, opcode 0110011, `reg_write_i`=1 → `pc_we` and `rf_we` high in cycle 4; `retired`=1; next FETCH in cycle 5.
- **Store with 3 wait cycles:** opcode 0100011 with `dmem_ack` after 3 cycles → `dmem_we`=1 throughout MEM; WB in cycle 8; `rf_we`=0.
- **Single step:** `run`=0 and `step` held high for 20 cycles → exactly one instruction retires, then `halted`=1 and `retired`=1.
- **Illegal opcode:** opcode 1111111 → TRAP after DECODE with `fault`=1; `pc_we` never asserted; stays in TRAP until reset.
- **Imem timeout:** `TIMEOUT_CYCLES`=4, `imem_ack` never asserted → TRAP with `fault`=2 exactly 4 cycles after FETCH entry. A second run with ack in cycle 4 → DECODE, no trap.
- **Reset during MEM:** `reset` low with `dmem_req` high → `dmem_req` low asynchronously; after release: IDLE, `retired`=0, `fault`=0.
